// File: rtl/pc_stack.sv
// Fetch-stage program counter with an integrated return-address stack.
// Each enabled cycle takes one of: return, call, jump or increment, in that priority.
module pc_stack #(
    parameter int               WIDTH    = 4,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       ld,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           A,
    output logic [WIDTH-1:0]           O,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       empty,
    output logic                       full,
    output logic                       err
);

    localparam int               SPW    = $clog2(DEPTH + 1);
    localparam int               IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);
    localparam logic [SPW-1:0]   SP_ONE = SPW'(1);
    localparam logic [SPW-1:0]   SP_MAX = SPW'(DEPTH);

    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic [WIDTH-1:0] o_inc;
    logic [WIDTH-1:0] o_nxt;
    logic [SPW-1:0]   sp_nxt;
    logic             err_nxt;
    logic             push;
    logic [IDXW-1:0]  wr_idx;
    logic [IDXW-1:0]  rd_idx;

    assign empty  = (sp == '0);
    assign full   = (sp == SP_MAX);
    assign o_inc  = O + PC_ONE;
    assign wr_idx = IDXW'(sp);
    assign rd_idx = IDXW'(sp - SP_ONE);

    // A rejected ret/call falls back to a plain increment and only raises err.
    always_comb begin
        o_nxt   = o_inc;
        sp_nxt  = sp;
        err_nxt = err;
        push    = 1'b0;
        if (ret) begin
            if (!empty) begin
                o_nxt  = stack_mem[rd_idx];
                sp_nxt = sp - SP_ONE;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (call) begin
            if (!full) begin
                push   = 1'b1;
                o_nxt  = A;
                sp_nxt = sp + SP_ONE;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (ld) begin
            o_nxt = A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            O   <= RESET_PC;
            sp  <= '0;
            err <= 1'b0;
        end else if (en) begin
            O   <= o_nxt;
            sp  <= sp_nxt;
            err <= err_nxt;
        end
    end

    // Stack contents need no reset: entries at sp and above are never read.
    always_ff @(posedge clk) begin
        if (rst_n && en && push) begin
            stack_mem[wr_idx] <= o_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed vector table for the documented scenarios,
// then a randomised phase checked against an independent queue-based model.
module tb_pc_stack;

    localparam int EW = 10;  // {O[3:0], sp[2:0], err, empty, full}

    typedef struct {
        logic       r;
        logic       e;
        logic       l;
        logic       c;
        logic       t;
        logic [3:0] a;
        logic [3:0] o;
        logic [2:0] s;
        logic       x;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          ld = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [3:0]    a_in = 4'd0;
    logic [3:0]    o;
    logic [2:0]    sp;
    logic          empty;
    logic          full;
    logic          err;

    logic [EW-1:0] exp_q[$];
    vec_t          vecs[$];
    int            total = 0;
    int            bad = 0;

    logic [3:0]    m_o;
    logic          m_err;
    logic [3:0]    m_stk[$];

    always #5 clk = ~clk;

    pc_stack #(.WIDTH(4), .DEPTH(4), .RESET_PC(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .ld    (ld),
        .call  (call),
        .ret   (ret),
        .A     (a_in),
        .O     (o),
        .sp    (sp),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    function automatic logic [EW-1:0] pack_exp(input logic [3:0] eo, input logic [2:0] es, input logic ex);
        return {eo, es, ex, (es == 3'd0), (es == 3'd4)};
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic apply(input logic r, input logic e, input logic l, input logic c, input logic t,
                         input logic [3:0] av, input logic [EW-1:0] exp_v, input string name);
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        @(negedge clk);
        rst_n = r; en = e; ld = l; call = c; ret = t; a_in = av;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        got  = {o, sp, err, empty, full};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got O=%h sp=%0d err=%b empty=%b full=%b, expected O=%h sp=%0d err=%b empty=%b full=%b",
                     name, got[9:6], got[5:3], got[2], got[1], got[0],
                     want[9:6], want[5:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic v(input logic r, input logic e, input logic l, input logic c, input logic t,
                     input logic [3:0] av, input logic [3:0] eo, input logic [2:0] es, input logic ex);
        vec_t tmp;
        tmp.r = r; tmp.e = e; tmp.l = l; tmp.c = c; tmp.t = t;
        tmp.a = av; tmp.o = eo; tmp.s = es; tmp.x = ex;
        vecs.push_back(tmp);
    endtask

    task automatic model_step(input logic r, input logic e, input logic l, input logic c, input logic t,
                              input logic [3:0] av);
        if (!r) begin
            m_o = 4'd0;
            m_err = 1'b0;
            m_stk.delete();
        end else if (e) begin
            if (t) begin
                if (m_stk.size() > 0) m_o = m_stk.pop_back();
                else begin m_o = m_o + 4'd1; m_err = 1'b1; end
            end else if (c) begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back(m_o + 4'd1);
                    m_o = av;
                end else begin
                    m_o = m_o + 4'd1;
                    m_err = 1'b1;
                end
            end else if (l) begin
                m_o = av;
            end else begin
                m_o = m_o + 4'd1;
            end
        end
    endtask

    initial begin
        // Reset held two cycles, then 17 increments wrapping through 15 -> 0.
        v(0,1,0,0,0, 4'h0, 4'h0, 0, 0);
        v(0,0,0,0,0, 4'h0, 4'h0, 0, 0);
        for (int i = 1; i <= 17; i++) v(1,1,0,0,0, 4'h0, 4'(i), 0, 0);
        // Load at O=3, then frozen with ld/A still toggling.
        v(1,1,0,0,0, 4'h0, 4'h2, 0, 0);
        v(1,1,0,0,0, 4'h0, 4'h3, 0, 0);
        v(1,1,1,0,0, 4'hA, 4'hA, 0, 0);
        for (int i = 0; i < 3; i++) v(1,0,1,1,1, 4'h5, 4'hA, 0, 0);
        // Nested call/return.
        v(0,1,0,0,0, 4'h0, 4'h0, 0, 0);
        v(1,1,0,0,0, 4'h0, 4'h1, 0, 0);
        v(1,1,0,0,0, 4'h0, 4'h2, 0, 0);
        v(1,1,0,1,0, 4'h8, 4'h8, 1, 0);
        v(1,1,0,1,0, 4'hC, 4'hC, 2, 0);
        v(1,1,0,0,1, 4'h0, 4'h9, 1, 0);
        v(1,1,0,0,1, 4'h0, 4'h3, 0, 0);
        // Fill the stack, overflow at O=C, then unwind in LIFO order with err sticky.
        v(1,1,0,1,0, 4'h0, 4'h0, 1, 0);
        v(1,1,0,1,0, 4'h5, 4'h5, 2, 0);
        v(1,1,0,1,0, 4'h9, 4'h9, 3, 0);
        v(1,1,0,1,0, 4'hC, 4'hC, 4, 0);
        v(1,1,0,1,0, 4'h1, 4'hD, 4, 1);
        v(1,1,0,0,1, 4'h0, 4'hA, 3, 1);
        v(1,1,0,0,1, 4'h0, 4'h6, 2, 1);
        v(1,1,0,0,1, 4'h0, 4'h1, 1, 1);
        v(1,1,0,0,1, 4'h0, 4'h4, 0, 1);
        // Underflow at O=5.
        v(0,1,0,0,0, 4'h0, 4'h0, 0, 0);
        for (int i = 1; i <= 5; i++) v(1,1,0,0,0, 4'h0, 4'(i), 0, 0);
        v(1,1,0,0,1, 4'h0, 4'h6, 0, 1);
        v(1,1,0,0,0, 4'h0, 4'h7, 0, 1);
        v(1,0,0,0,1, 4'h0, 4'h7, 0, 1);
        // Priority: ret beats call and ld; then call beats ld with a wrapped push.
        v(0,1,0,0,0, 4'h0, 4'h0, 0, 0);
        v(1,1,1,0,0, 4'h6, 4'h6, 0, 0);
        v(1,1,0,1,0, 4'hB, 4'hB, 1, 0);
        v(1,1,1,1,1, 4'h2, 4'h7, 0, 0);
        v(1,1,0,0,1, 4'h0, 4'h8, 0, 1);
        v(0,1,0,0,0, 4'h0, 4'h0, 0, 0);
        v(1,1,1,0,0, 4'hF, 4'hF, 0, 0);
        v(1,1,1,1,0, 4'h4, 4'h4, 1, 0);
        v(1,1,0,0,1, 4'h0, 4'h0, 0, 0);
        // Reset mid-operation with sp=3, err=1 and call asserted.
        v(1,1,0,1,0, 4'h1, 4'h1, 1, 0);
        v(1,1,0,1,0, 4'h2, 4'h2, 2, 0);
        v(1,1,0,1,0, 4'h3, 4'h3, 3, 0);
        v(1,1,0,1,0, 4'h4, 4'h4, 4, 0);
        v(1,1,0,1,0, 4'h5, 4'h5, 4, 1);
        v(1,1,0,0,1, 4'h0, 4'h4, 3, 1);
        v(0,1,0,1,0, 4'h9, 4'h0, 0, 0);
        v(1,1,0,0,1, 4'h0, 4'h1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].c, vecs[i].t, vecs[i].a,
                  pack_exp(vecs[i].o, vecs[i].s, vecs[i].x), $sformatf("vec%0d", i));
        end

        // Randomised phase against the reference model.
        model_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, pack_exp(m_o, 3'(m_stk.size()), m_err), "rnd_reset");
        for (int i = 0; i < 400; i++) begin
            logic r, e, l, c, t;
            logic [3:0] av;
            r  = ($urandom_range(0, 60) != 0);
            e  = ($urandom_range(0, 4) != 0);
            l  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 2) == 0);
            av = 4'($urandom_range(0, 15));
            model_step(r, e, l, c, t, av);
            apply(r, e, l, c, t, av, pack_exp(m_o, 3'(m_stk.size()), m_err), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
